// File: rtl/urv_dm_arbiter.sv
// -----------------------------------------------------------------------------
// urv_dm_arbiter
//
// Two-master arbiter in front of the single data-memory port.
//   master 0 : core exec stage (load/store, stalls until cpu_ready_o)
//   master 1 : host/debug requester
// Only one access is outstanding at a time. The core normally has priority;
// a saturating starvation counter lets a waiting host win once it has waited
// g_starve_limit cycles. An ack timeout completes a stuck access with an error
// so neither master can hang forever.
//
// Parameters
//   g_starve_limit : host wait cycles before it beats the core (>= 1)
//   g_timeout      : cycles without mem_ack_i before abort, 0 disables
//
// Ports
//   clk_i, rst_i          : clock (rising edge), synchronous active-low reset
//   cpu_addr/data/sel_i   : core request fields
//   cpu_load_i/store_i    : core request levels, held until cpu_ready_o
//   cpu_ready_o           : one-cycle completion pulse to the core
//   cpu_rdata_o/err_o     : load data / timeout flag, valid with cpu_ready_o
//   host_addr/data/sel_i  : host request fields
//   host_we_i, host_req_i : host direction and request level
//   host_ready_o          : one-cycle completion pulse to the host
//   host_rdata_o/err_o    : read data / timeout flag, valid with host_ready_o
//   mem_addr/data/sel/we_o: memory request fields, registered at grant
//   mem_req_o             : held until mem_ack_i or timeout
//   mem_ack_i, mem_rdata_i: memory completion and same-cycle read data
// -----------------------------------------------------------------------------
module urv_dm_arbiter #(
  parameter int g_starve_limit = 8,
  parameter int g_timeout      = 255
) (
  input  logic        clk_i,
  input  logic        rst_i,

  input  logic [31:0] cpu_addr_i,
  input  logic [31:0] cpu_data_i,
  input  logic [3:0]  cpu_sel_i,
  input  logic        cpu_load_i,
  input  logic        cpu_store_i,
  output logic        cpu_ready_o,
  output logic [31:0] cpu_rdata_o,
  output logic        cpu_err_o,

  input  logic [31:0] host_addr_i,
  input  logic [31:0] host_data_i,
  input  logic [3:0]  host_sel_i,
  input  logic        host_we_i,
  input  logic        host_req_i,
  output logic        host_ready_o,
  output logic [31:0] host_rdata_o,
  output logic        host_err_o,

  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_data_o,
  output logic [3:0]  mem_sel_o,
  output logic        mem_we_o,
  output logic        mem_req_o,
  input  logic        mem_ack_i,
  input  logic [31:0] mem_rdata_i
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CPU  = 2'd1,
    ST_HOST = 2'd2
  } state_t;

  // Counter widths sized to hold their terminal values.
  localparam int ST_W  = $clog2(g_starve_limit + 1);
  localparam int TMO_W = $clog2(g_timeout + 2);

  localparam logic [ST_W-1:0]  STARVE_MAX = ST_W'(g_starve_limit);
  // The counter reads g_timeout-1 on the last waiting cycle; expiry fires on
  // that cycle's edge, so mem_req_o is high for exactly g_timeout cycles.
  localparam logic [TMO_W-1:0] TMO_LAST   = TMO_W'((g_timeout > 0) ? g_timeout - 1 : 0);
  localparam logic             TMO_EN     = (g_timeout > 0);

  state_t             state;
  logic [ST_W-1:0]    starve_cnt;
  logic [TMO_W-1:0]   tmo_cnt;

  logic cpu_req;
  logic host_win;
  logic tmo_expire;
  logic access_done;
  logic [31:0] done_rdata;

  assign cpu_req  = cpu_load_i | cpu_store_i;
  // Host takes the port when the core is quiet, or once it has starved long enough.
  assign host_win = host_req_i & (~cpu_req | (starve_cnt >= STARVE_MAX));

  // An ack in the expiry cycle wins: expiry is only considered without ack.
  assign tmo_expire  = TMO_EN & mem_req_o & ~mem_ack_i & (tmo_cnt == TMO_LAST);
  assign access_done = mem_req_o & (mem_ack_i | tmo_expire);
  // Writes and timed-out accesses return zero data.
  assign done_rdata  = (mem_ack_i & ~mem_we_o) ? mem_rdata_i : 32'h0;

  // NOTE: all state below is updated with non-blocking assignments so every
  // register sees the pre-edge values of the others, regardless of ordering.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state        <= ST_IDLE;
      starve_cnt   <= '0;
      tmo_cnt      <= '0;
      cpu_ready_o  <= 1'b0;
      cpu_rdata_o  <= 32'h0;
      cpu_err_o    <= 1'b0;
      host_ready_o <= 1'b0;
      host_rdata_o <= 32'h0;
      host_err_o   <= 1'b0;
      mem_addr_o   <= 32'h0;
      mem_data_o   <= 32'h0;
      mem_sel_o    <= 4'h0;
      mem_we_o     <= 1'b0;
      mem_req_o    <= 1'b0;
    end else begin
      // Completion strobes are single-cycle pulses.
      cpu_ready_o  <= 1'b0;
      cpu_err_o    <= 1'b0;
      host_ready_o <= 1'b0;
      host_err_o   <= 1'b0;

      // Starvation: counts host wait cycles outside its own access, saturating.
      if (!host_req_i || (state == ST_IDLE && host_win)) begin
        starve_cnt <= '0;
      end else if (state != ST_HOST && starve_cnt != STARVE_MAX) begin
        starve_cnt <= starve_cnt + 1'b1;
      end

      unique case (state)
        ST_IDLE: begin
          if (host_win) begin
            state      <= ST_HOST;
            mem_addr_o <= host_addr_i;
            mem_data_o <= host_data_i;
            mem_sel_o  <= host_sel_i;
            mem_we_o   <= host_we_i;
            mem_req_o  <= 1'b1;
            tmo_cnt    <= '0;
          end else if (cpu_req) begin
            state      <= ST_CPU;
            mem_addr_o <= cpu_addr_i;
            mem_data_o <= cpu_data_i;
            mem_sel_o  <= cpu_sel_i;
            // Store has priority when both load and store are raised.
            mem_we_o   <= cpu_store_i;
            mem_req_o  <= 1'b1;
            tmo_cnt    <= '0;
          end
        end

        ST_CPU, ST_HOST: begin
          if (access_done) begin
            state     <= ST_IDLE;
            mem_req_o <= 1'b0;
            if (state == ST_CPU) begin
              cpu_ready_o <= 1'b1;
              cpu_rdata_o <= done_rdata;
              cpu_err_o   <= ~mem_ack_i;
            end else begin
              host_ready_o <= 1'b1;
              host_rdata_o <= done_rdata;
              host_err_o   <= ~mem_ack_i;
            end
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
        end

        default: begin
          state     <= ST_IDLE;
          mem_req_o <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_urv_dm_arbiter.sv
// -----------------------------------------------------------------------------
// tb_urv_dm_arbiter
//
// Directed scenarios followed by a randomized phase. Expected outputs come from
// a reference model that tracks who owns the memory port, how long the current
// access has been outstanding and how long the host has been waiting.
// -----------------------------------------------------------------------------
module tb_urv_dm_arbiter;

  localparam int STARVE = 8;
  localparam int TMO    = 4;

  localparam int ACK_NEVER  = 0;
  localparam int ACK_FIXED  = 1;
  localparam int ACK_ALWAYS = 2;
  localparam int ACK_RANDOM = 3;

  localparam int OWN_NONE = 0;
  localparam int OWN_CPU  = 1;
  localparam int OWN_HOST = 2;

  logic        clk_i;
  logic        rst_i;
  logic [31:0] cpu_addr_i, cpu_data_i;
  logic [3:0]  cpu_sel_i;
  logic        cpu_load_i, cpu_store_i;
  logic        cpu_ready_o, cpu_err_o;
  logic [31:0] cpu_rdata_o;
  logic [31:0] host_addr_i, host_data_i;
  logic [3:0]  host_sel_i;
  logic        host_we_i, host_req_i;
  logic        host_ready_o, host_err_o;
  logic [31:0] host_rdata_o;
  logic [31:0] mem_addr_o, mem_data_o;
  logic [3:0]  mem_sel_o;
  logic        mem_we_o, mem_req_o;
  logic        mem_ack_i;
  logic [31:0] mem_rdata_i;

  urv_dm_arbiter #(
    .g_starve_limit(STARVE),
    .g_timeout     (TMO)
  ) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .cpu_addr_i  (cpu_addr_i),
    .cpu_data_i  (cpu_data_i),
    .cpu_sel_i   (cpu_sel_i),
    .cpu_load_i  (cpu_load_i),
    .cpu_store_i (cpu_store_i),
    .cpu_ready_o (cpu_ready_o),
    .cpu_rdata_o (cpu_rdata_o),
    .cpu_err_o   (cpu_err_o),
    .host_addr_i (host_addr_i),
    .host_data_i (host_data_i),
    .host_sel_i  (host_sel_i),
    .host_we_i   (host_we_i),
    .host_req_i  (host_req_i),
    .host_ready_o(host_ready_o),
    .host_rdata_o(host_rdata_o),
    .host_err_o  (host_err_o),
    .mem_addr_o  (mem_addr_o),
    .mem_data_o  (mem_data_o),
    .mem_sel_o   (mem_sel_o),
    .mem_we_o    (mem_we_o),
    .mem_req_o   (mem_req_o),
    .mem_ack_i   (mem_ack_i),
    .mem_rdata_i (mem_rdata_i)
  );

  initial begin
    clk_i = 1'b0;
    forever #5 clk_i = ~clk_i;
  end

  int checks   = 0;
  int failures = 0;

  // Memory responder configuration.
  int          ack_mode  = ACK_NEVER;
  int          ack_delay = 0;
  logic [31:0] rdata_src = 32'h0;

  // Reference model state.
  int          m_owner        = OWN_NONE;
  int          m_elapsed      = 0;
  int          m_starve       = 0;
  bit          m_fields_valid = 1'b0;
  logic [31:0] e_mem_addr = '0, e_mem_data = '0;
  logic [3:0]  e_mem_sel = '0;
  logic        e_mem_we = 1'b0, e_mem_req = 1'b0;
  logic        e_cpu_ready = 1'b0, e_cpu_err = 1'b0;
  logic        e_host_ready = 1'b0, e_host_err = 1'b0;
  logic [31:0] e_cpu_rdata = '0, e_host_rdata = '0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic drive_mem();
    case (ack_mode)
      ACK_FIXED:  mem_ack_i = e_mem_req && (m_elapsed == ack_delay);
      ACK_ALWAYS: mem_ack_i = 1'b1;
      ACK_RANDOM: begin
        mem_ack_i = ($urandom_range(0, 2) == 0);
        rdata_src = $urandom;
      end
      default:    mem_ack_i = 1'b0;
    endcase
    mem_rdata_i = rdata_src;
  endtask

  // Advance the model by one clock using the inputs present before the edge.
  task automatic model_step();
    bit          cpu_wants, host_gets, expired;
    logic [31:0] rd;
    if (!rst_i) begin
      m_owner = OWN_NONE; m_elapsed = 0; m_starve = 0; m_fields_valid = 1'b1;
      e_mem_addr = '0; e_mem_data = '0; e_mem_sel = '0; e_mem_we = 1'b0; e_mem_req = 1'b0;
      e_cpu_ready = 1'b0; e_cpu_err = 1'b0; e_cpu_rdata = '0;
      e_host_ready = 1'b0; e_host_err = 1'b0; e_host_rdata = '0;
      return;
    end
    cpu_wants = cpu_load_i || cpu_store_i;
    host_gets = (m_owner == OWN_NONE) && host_req_i && (!cpu_wants || m_starve >= STARVE);
    e_cpu_ready = 1'b0; e_cpu_err = 1'b0; e_host_ready = 1'b0; e_host_err = 1'b0;

    if (!host_req_i || host_gets) m_starve = 0;
    else if (m_owner != OWN_HOST) m_starve = (m_starve < STARVE) ? m_starve + 1 : STARVE;

    if (m_owner == OWN_NONE) begin
      if (host_gets) begin
        m_owner = OWN_HOST;
        e_mem_addr = host_addr_i; e_mem_data = host_data_i;
        e_mem_sel = host_sel_i; e_mem_we = host_we_i;
      end else if (cpu_wants) begin
        m_owner = OWN_CPU;
        e_mem_addr = cpu_addr_i; e_mem_data = cpu_data_i;
        e_mem_sel = cpu_sel_i; e_mem_we = cpu_store_i;
      end
      if (m_owner != OWN_NONE) begin
        e_mem_req = 1'b1; m_elapsed = 0; m_fields_valid = 1'b0;
      end
    end else begin
      expired = !mem_ack_i && (TMO > 0) && (m_elapsed + 1 >= TMO);
      if (mem_ack_i || expired) begin
        rd = (mem_ack_i && !e_mem_we) ? mem_rdata_i : 32'h0;
        if (m_owner == OWN_CPU) begin
          e_cpu_ready = 1'b1; e_cpu_rdata = rd; e_cpu_err = expired;
        end else begin
          e_host_ready = 1'b1; e_host_rdata = rd; e_host_err = expired;
        end
        e_mem_req = 1'b0;
        m_owner   = OWN_NONE;
      end else begin
        m_elapsed++;
      end
    end
  endtask

  task automatic compare();
    check("mem_req", {31'b0, mem_req_o}, {31'b0, e_mem_req});
    if (e_mem_req || m_fields_valid) begin
      check("mem_addr", mem_addr_o, e_mem_addr);
      check("mem_data", mem_data_o, e_mem_data);
      check("mem_sel", {28'b0, mem_sel_o}, {28'b0, e_mem_sel});
      check("mem_we", {31'b0, mem_we_o}, {31'b0, e_mem_we});
    end
    check("cpu_ready", {31'b0, cpu_ready_o}, {31'b0, e_cpu_ready});
    check("cpu_err", {31'b0, cpu_err_o}, {31'b0, e_cpu_err});
    check("cpu_rdata", cpu_rdata_o, e_cpu_rdata);
    check("host_ready", {31'b0, host_ready_o}, {31'b0, e_host_ready});
    check("host_err", {31'b0, host_err_o}, {31'b0, e_host_err});
    check("host_rdata", host_rdata_o, e_host_rdata);
    check("ready_exclusive", {31'b0, cpu_ready_o & host_ready_o}, 32'h0);
  endtask

  // One clock: responder drives, model steps, DUT is sampled 1 ns after the edge.
  task automatic tick();
    drive_mem();
    model_step();
    @(posedge clk_i);
    #1;
    compare();
  endtask

  task automatic wait_ready(input bit host, input int budget, output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (!(host ? host_ready_o : cpu_ready_o) && n < budget);
    if (host) check("host_ready_seen", {31'b0, host_ready_o}, 32'h1);
    else      check("cpu_ready_seen", {31'b0, cpu_ready_o}, 32'h1);
  endtask

  initial begin
    int  n, reqcnt, kind;
    bit  granted, cpu_busy, host_busy;

    rst_i = 1'b0;
    cpu_addr_i = '0; cpu_data_i = '0; cpu_sel_i = '0; cpu_load_i = 1'b0; cpu_store_i = 1'b0;
    host_addr_i = '0; host_data_i = '0; host_sel_i = '0; host_we_i = 1'b0; host_req_i = 1'b0;
    mem_ack_i = 1'b0; mem_rdata_i = '0;

    // Reset state.
    tick();
    tick();
    rst_i = 1'b1;
    tick();

    // 1: core load, ack two cycles after mem_req_o.
    ack_mode = ACK_FIXED; ack_delay = 2; rdata_src = 32'hDEADBEEF;
    cpu_addr_i = 32'h100; cpu_sel_i = 4'hF; cpu_load_i = 1'b1;
    tick();
    wait_ready(1'b0, 10, n);
    check("t1_latency", n, 3);
    check("t1_rdata", cpu_rdata_o, 32'hDEADBEEF);
    check("t1_err", {31'b0, cpu_err_o}, 32'h0);
    cpu_load_i = 1'b0;
    tick();
    check("t1_single_pulse", {31'b0, cpu_ready_o}, 32'h0);

    // 2: core store and host read in the same cycle; core first.
    ack_mode = ACK_FIXED; ack_delay = 0; rdata_src = 32'hA5A50001;
    cpu_addr_i = 32'h200; cpu_data_i = 32'h12345678; cpu_sel_i = 4'b0011; cpu_store_i = 1'b1;
    host_addr_i = 32'h300; host_data_i = 32'h0; host_sel_i = 4'hF; host_we_i = 1'b0; host_req_i = 1'b1;
    tick();
    check("t2_core_first_addr", mem_addr_o, 32'h200);
    check("t2_core_we", {31'b0, mem_we_o}, 32'h1);
    check("t2_core_sel", {28'b0, mem_sel_o}, 32'h3);
    wait_ready(1'b0, 10, n);
    cpu_store_i = 1'b0;
    tick();
    check("t2_host_next_addr", mem_addr_o, 32'h300);
    check("t2_host_we", {31'b0, mem_we_o}, 32'h0);
    wait_ready(1'b1, 10, n);
    check("t2_host_rdata", host_rdata_o, 32'hA5A50001);
    host_req_i = 1'b0;
    tick();

    // 3: both request continuously, ack every cycle; host must not starve.
    ack_mode = ACK_ALWAYS; rdata_src = 32'h0BADF00D;
    cpu_addr_i = 32'h500; cpu_sel_i = 4'hF; cpu_load_i = 1'b1;
    host_addr_i = 32'h600; host_we_i = 1'b0; host_req_i = 1'b1;
    granted = 1'b0; n = 0;
    for (int i = 0; i < 30; i++) begin
      tick();
      n++;
      if (mem_req_o && mem_addr_o == 32'h600) begin
        granted = 1'b1;
        break;
      end
    end
    check("t3_host_granted", {31'b0, granted}, 32'h1);
    check("t3_wait_within_limit", {31'b0, (n - 1) <= STARVE}, 32'h1);
    wait_ready(1'b1, 5, n);
    host_req_i = 1'b0;
    tick();
    check("t3_core_resumes", mem_addr_o, 32'h500);
    wait_ready(1'b0, 5, n);
    cpu_load_i = 1'b0;
    tick();

    // 4: host read with no ack ever; times out after exactly TMO cycles.
    ack_mode = ACK_NEVER;
    host_addr_i = 32'h400; host_we_i = 1'b0; host_req_i = 1'b1;
    reqcnt = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (mem_req_o) reqcnt++;
      if (host_ready_o) break;
    end
    check("t4_req_cycles", reqcnt, TMO);
    check("t4_ready", {31'b0, host_ready_o}, 32'h1);
    check("t4_err", {31'b0, host_err_o}, 32'h1);
    check("t4_rdata_zero", host_rdata_o, 32'h0);
    host_req_i = 1'b0;
    tick();
    check("t4_idle_after", {31'b0, mem_req_o}, 32'h0);

    // 5: reset in the middle of a core access.
    ack_mode = ACK_NEVER;
    cpu_addr_i = 32'h700; cpu_sel_i = 4'hF; cpu_load_i = 1'b1;
    tick();
    tick();
    rst_i = 1'b0;
    tick();
    check("t5_req_dropped", {31'b0, mem_req_o}, 32'h0);
    check("t5_no_ready", {31'b0, cpu_ready_o}, 32'h0);
    rst_i = 1'b1;
    ack_mode = ACK_FIXED; ack_delay = 1; rdata_src = 32'hCAFEF00D;
    wait_ready(1'b0, 10, n);
    check("t5_rdata_after_reset", cpu_rdata_o, 32'hCAFEF00D);
    check("t5_err_after_reset", {31'b0, cpu_err_o}, 32'h0);
    cpu_load_i = 1'b0;
    tick();

    // 6: load and store together -> issued as a store.
    ack_mode = ACK_FIXED; ack_delay = 0; rdata_src = 32'h11112222;
    cpu_addr_i = 32'h800; cpu_data_i = 32'h55AA55AA; cpu_sel_i = 4'hF;
    cpu_load_i = 1'b1; cpu_store_i = 1'b1;
    tick();
    check("t6_store_wins", {31'b0, mem_we_o}, 32'h1);
    wait_ready(1'b0, 10, n);
    check("t6_write_rdata_zero", cpu_rdata_o, 32'h0);
    cpu_load_i = 1'b0; cpu_store_i = 1'b0;
    tick();

    // Randomized traffic from both masters with random ack timing and resets.
    ack_mode = ACK_RANDOM;
    cpu_busy = 1'b0; host_busy = 1'b0;
    for (int i = 0; i < 600; i++) begin
      if (!cpu_busy && $urandom_range(0, 2) == 0) begin
        cpu_addr_i = $urandom; cpu_data_i = $urandom; cpu_sel_i = 4'($urandom);
        kind = $urandom_range(1, 3);
        cpu_load_i = (kind & 1) != 0;
        cpu_store_i = (kind & 2) != 0;
        cpu_busy = 1'b1;
      end
      if (!host_busy && $urandom_range(0, 3) == 0) begin
        host_addr_i = $urandom; host_data_i = $urandom; host_sel_i = 4'($urandom);
        host_we_i = 1'($urandom);
        host_req_i = 1'b1;
        host_busy = 1'b1;
      end
      rst_i = ($urandom_range(0, 199) == 0) ? 1'b0 : 1'b1;
      tick();
      if (e_cpu_ready || !rst_i) begin
        cpu_load_i = 1'b0; cpu_store_i = 1'b0; cpu_busy = 1'b0;
      end
      if (e_host_ready || !rst_i) begin
        host_req_i = 1'b0; host_busy = 1'b0;
      end
    end
    rst_i = 1'b1;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
